// File: rtl/instruction_loader.sv
// Instruction RAM writer: streams host bytes into a 256x8 RAM and holds the core in
// reset (cpu_reset low) until a complete program has been loaded.
module instruction_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [1:0] {StIdle, StLoad, StRelease} state_e;

    // DEPTH == 2**ADDR_W, so the largest legal length is a lone MSB in ADDR_W+1 bits.
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W:0]     count_inc;
    logic                len_ok;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        count_d     = count_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        wr_en       = 1'b0;
        in_ready    = (state_q == StLoad);
        busy        = (state_q == StLoad) || (state_q == StRelease);
        wr_addr     = base_q + count_q[ADDR_W-1:0];
        count_inc   = count_q + 1'b1;
        len_ok      = (length != '0) && (length <= MaxLen);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (len_ok) begin
                        base_d      = base_addr;
                        len_d       = length;
                        count_d     = '0;
                        cpu_reset_d = 1'b0;
                        state_d     = StLoad;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                state_d     = StIdle;
                done_d      = 1'b1;
                cpu_reset_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            count_q     <= count_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // RAM is deliberately outside the reset domain so a partial load survives reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= in_data;
        end
    end

    assign fetch_data = mem_q[fetch_addr];
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign error      = error_q;
    assign byte_count = count_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;
    logic [8:0] byte_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] pay [256];
    logic [5:0] vpat;
    int         idx;

    instruction_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input logic [7:0] a, input logic [7:0] e);
        fetch_addr = a;
        #1;
        check(tag, {8'h00, fetch_data}, {8'h00, e});
    endtask

    // Start a load and push n bytes from pay[] back-to-back.
    task automatic do_load(input logic [7:0] b, input logic [8:0] l, input int n);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start = 1'b0;
        check("start_cpu_reset_low", {15'd0, cpu_reset}, 16'd0);
        check("start_busy", {15'd0, busy}, 16'd1);
        check("start_count_clear", {7'd0, byte_count}, 16'd0);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = pay[i];
            check("beat_in_ready", {15'd0, in_ready}, 16'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Expect to be in the single release cycle, then see done with cpu_reset rising.
    task automatic finish_release(input logic [8:0] cnt);
        check("rel_in_ready", {15'd0, in_ready}, 16'd0);
        check("rel_busy", {15'd0, busy}, 16'd1);
        check("rel_done_low", {15'd0, done}, 16'd0);
        check("rel_cpu_reset_low", {15'd0, cpu_reset}, 16'd0);
        check("rel_count", {7'd0, byte_count}, {7'd0, cnt});
        tick();
        check("done_pulse", {15'd0, done}, 16'd1);
        check("done_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        check("done_busy", {15'd0, busy}, 16'd0);
        tick();
        check("done_single", {15'd0, done}, 16'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = '0;
        length     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        fetch_addr = '0;
        #3 reset = 1'b0;
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_done", {15'd0, done}, 16'd0);
        check("rst_error", {15'd0, error}, 16'd0);
        check("rst_count", {7'd0, byte_count}, 16'd0);
        check("rst_cpu_reset", {15'd0, cpu_reset}, 16'd0);
        tick();
        reset = 1'b1;
        tick();

        // Basic 4-byte load at 0x00
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'hC5;
        do_load(8'h00, 9'd4, 4);
        finish_release(9'd4);
        check_mem("ram_00", 8'h00, 8'h11);
        check_mem("ram_03", 8'h03, 8'hC5);

        // Wrap-around load
        pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
        do_load(8'hFE, 9'd3, 3);
        finish_release(9'd3);
        check("wrap_count", {7'd0, byte_count}, 16'd3);
        check_mem("wrap_fe", 8'hFE, 8'hA1);
        check_mem("wrap_ff", 8'hFF, 8'hA2);
        check_mem("wrap_00", 8'h00, 8'hA3);
        check_mem("wrap_01_kept", 8'h01, 8'h22);

        // Illegal lengths
        start = 1'b1; length = 9'd0; base_addr = 8'h20;
        tick();
        start = 1'b0;
        check("len0_error", {15'd0, error}, 16'd1);
        check("len0_in_ready", {15'd0, in_ready}, 16'd0);
        check("len0_busy", {15'd0, busy}, 16'd0);
        check("len0_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        tick();
        check("len0_error_single", {15'd0, error}, 16'd0);
        start = 1'b1; length = 9'd257;
        tick();
        start = 1'b0;
        check("len257_error", {15'd0, error}, 16'd1);
        check("len257_in_ready", {15'd0, in_ready}, 16'd0);
        check("len257_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        tick();
        check("len257_error_single", {15'd0, error}, 16'd0);
        check("len257_idle", {15'd0, busy}, 16'd0);

        // Stalled load with a start pulse mid-load
        pay[0] = 8'h51; pay[1] = 8'h52; pay[2] = 8'h53;
        vpat = 6'b101001;
        idx  = 0;
        do_load(8'h40, 9'd3, 0);
        for (int c = 0; c < 6; c++) begin
            in_valid  = vpat[c];
            in_data   = pay[idx];
            start     = (c == 2);
            base_addr = 8'h80;
            length    = 9'd5;
            check("stall_busy", {15'd0, busy}, 16'd1);
            tick();
            if (vpat[c]) idx++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        finish_release(9'd3);
        check_mem("stall_40", 8'h40, 8'h51);
        check_mem("stall_41", 8'h41, 8'h52);
        check_mem("stall_42", 8'h42, 8'h53);

        // Reset after 2 of 5 bytes
        pay[0] = 8'h61; pay[1] = 8'h62;
        do_load(8'h60, 9'd5, 2);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {15'd0, busy}, 16'd0);
        check("midrst_in_ready", {15'd0, in_ready}, 16'd0);
        check("midrst_count", {7'd0, byte_count}, 16'd0);
        check("midrst_cpu_reset", {15'd0, cpu_reset}, 16'd0);
        check("midrst_done", {15'd0, done}, 16'd0);
        reset = 1'b1;
        check_mem("midrst_60", 8'h60, 8'h61);
        check_mem("midrst_61", 8'h61, 8'h62);
        tick();
        pay[0] = 8'h99;
        do_load(8'h70, 9'd1, 1);
        finish_release(9'd1);
        check_mem("post_rst_70", 8'h70, 8'h99);

        // Full-depth load starting mid-RAM
        for (int i = 0; i < 256; i++) pay[i] = 8'(i) ^ 8'h5A;
        do_load(8'h80, 9'd256, 256);
        finish_release(9'd256);
        check_mem("full_80", 8'h80, 8'h5A);
        check_mem("full_7f", 8'h7F, 8'hA5);
        check_mem("full_10", 8'h10, 8'hCA);

        // Single-byte reload; read during the write cycle sees the old value
        pay[0] = 8'h7F;
        check("reload_pre_cpu_reset", {15'd0, cpu_reset}, 16'd1);
        fetch_addr = 8'h10;
        do_load(8'h10, 9'd1, 0);
        in_valid = 1'b1;
        in_data  = 8'h7F;
        #1;
        check("same_cycle_old", {8'h00, fetch_data}, 16'h00CA);
        tick();
        in_valid = 1'b0;
        finish_release(9'd1);
        check_mem("reload_10", 8'h10, 8'h7F);
        check_mem("reload_0f", 8'h0F, 8'hD5);
        check_mem("reload_11", 8'h11, 8'hCB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
